// File: rtl/nibble_seq_if.sv
// Bus bundle between the nibble_seq core and its instruction ROM, data RAM,
// external ALU and I/O ports; master is the core side.
interface nibble_seq_if;
    logic [7:0]  imem_addr;
    logic [11:0] imem_data;
    logic [3:0]  dmem_addr;
    logic [3:0]  dmem_wdata;
    logic        dmem_we;
    logic [3:0]  dmem_rdata;
    logic [2:0]  alu_op;
    logic [3:0]  alu_a;
    logic [3:0]  alu_b;
    logic [3:0]  alu_out;
    logic        alu_carry;
    logic        alu_zero;
    logic [3:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  acc;
    logic        carry_flag;
    logic        zero_flag;
    logic        halted;

    modport master (
        output imem_addr, dmem_addr, dmem_wdata, dmem_we, alu_op, alu_a, alu_b,
               in_ready, out_data, out_valid, acc, carry_flag, zero_flag, halted,
        input  imem_data, dmem_rdata, alu_out, alu_carry, alu_zero,
               in_data, in_valid, out_ready
    );

    modport slave (
        input  imem_addr, dmem_addr, dmem_wdata, dmem_we, alu_op, alu_a, alu_b,
               in_ready, out_data, out_valid, acc, carry_flag, zero_flag, halted,
        output imem_data, dmem_rdata, alu_out, alu_carry, alu_zero,
               in_data, in_valid, out_ready
    );
endinterface

// File: rtl/nibble_seq.sv
// 4-bit accumulator sequencer: fetches 12-bit instructions from a synchronous ROM,
// drives an external ALU, a synchronous data RAM and handshaked I/O ports.
module nibble_seq #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic           clk,
    input  logic           rst_n,
    nibble_seq_if.master   bus
);
    localparam int unsigned PC_W = 8;
    localparam int unsigned DW   = 4;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_MEM, S_EXEC, S_IO_WAIT, S_HALT
    } state_t;

    localparam logic [3:0] OP_LIT  = 4'h0;
    localparam logic [3:0] OP_IN   = 4'h1;
    localparam logic [3:0] OP_LD   = 4'h2;
    localparam logic [3:0] OP_ST   = 4'h3;
    localparam logic [3:0] OP_OUT  = 4'h4;
    localparam logic [3:0] OP_ADDI = 4'h5;
    localparam logic [3:0] OP_ADDM = 4'h6;
    localparam logic [3:0] OP_CMPI = 4'h7;
    localparam logic [3:0] OP_CMPM = 4'h8;
    localparam logic [3:0] OP_NORI = 4'h9;
    localparam logic [3:0] OP_NORM = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_JZ   = 4'hC;
    localparam logic [3:0] OP_JNZ  = 4'hD;
    localparam logic [3:0] OP_JC   = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] ALU_OUT = 3'b000;
    localparam logic [2:0] ALU_CMP = 3'b001;
    localparam logic [2:0] ALU_LD  = 3'b010;
    localparam logic [2:0] ALU_ADD = 3'b011;
    localparam logic [2:0] ALU_NOR = 3'b100;

    state_t          state, state_nxt;
    logic [PC_W-1:0] pc;
    logic [3:0]      ir_op;
    logic [DW-1:0]   ir_arg;
    logic [DW-1:0]   acc;
    logic            carry_flag;
    logic            zero_flag;
    logic            halted;

    logic [3:0]      dec_op;
    logic            jump_taken_c;
    logic            mem_operand_c;
    logic            acc_wr_c;
    logic            flag_wr_c;
    logic            dmem_we_c;
    logic            in_ready_c;
    logic            out_valid_c;
    logic [2:0]      alu_op_c;

    assign dec_op        = bus.imem_data[11:8];
    assign mem_operand_c = ir_op inside {OP_LD, OP_ADDM, OP_CMPM, OP_NORM};
    assign acc_wr_c      = ir_op inside {OP_LIT, OP_LD, OP_ADDI, OP_ADDM, OP_NORI, OP_NORM};
    assign flag_wr_c     = ir_op inside {OP_ADDI, OP_ADDM, OP_CMPI, OP_CMPM, OP_NORI, OP_NORM};

    // Branches resolve in DECODE against the word arriving from the ROM.
    always_comb begin
        jump_taken_c = 1'b0;
        case (dec_op)
            OP_JMP:  jump_taken_c = 1'b1;
            OP_JZ:   jump_taken_c = zero_flag;
            OP_JNZ:  jump_taken_c = ~zero_flag;
            OP_JC:   jump_taken_c = carry_flag;
            default: jump_taken_c = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= state_nxt;
    end

    // Next state plus the state-decoded strobes (zero everywhere except their own state).
    always_comb begin
        state_nxt   = state;
        dmem_we_c   = 1'b0;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        alu_op_c    = ALU_OUT;
        case (state)
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: begin
                case (dec_op)
                    OP_LD, OP_ADDM, OP_CMPM, OP_NORM: state_nxt = S_MEM;
                    OP_IN, OP_OUT:                    state_nxt = S_IO_WAIT;
                    OP_JMP, OP_JZ, OP_JNZ, OP_JC:     state_nxt = S_FETCH;
                    OP_HALT:                          state_nxt = S_HALT;
                    default:                          state_nxt = S_EXEC;
                endcase
            end
            S_MEM:    state_nxt = S_EXEC;
            S_EXEC: begin
                state_nxt = S_FETCH;
                dmem_we_c = (ir_op == OP_ST);
                case (ir_op)
                    OP_LIT, OP_LD:     alu_op_c = ALU_LD;
                    OP_ADDI, OP_ADDM:  alu_op_c = ALU_ADD;
                    OP_CMPI, OP_CMPM:  alu_op_c = ALU_CMP;
                    OP_NORI, OP_NORM:  alu_op_c = ALU_NOR;
                    default:           alu_op_c = ALU_OUT;
                endcase
            end
            S_IO_WAIT: begin
                in_ready_c  = (ir_op == OP_IN);
                out_valid_c = (ir_op == OP_OUT);
                if ((in_ready_c && bus.in_valid) || (out_valid_c && bus.out_ready))
                    state_nxt = S_FETCH;
            end
            S_HALT:   state_nxt = S_HALT;
            default:  state_nxt = S_FETCH;
        endcase
    end

    // Architectural registers; HALT simply never matches an updating state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            ir_op      <= 4'h0;
            ir_arg     <= 4'h0;
            acc        <= 4'h0;
            carry_flag <= 1'b0;
            zero_flag  <= 1'b0;
            halted     <= 1'b0;
        end else begin
            case (state)
                S_DECODE: begin
                    ir_op  <= dec_op;
                    ir_arg <= bus.imem_data[3:0];
                    pc     <= jump_taken_c ? bus.imem_data[7:0] : pc + PC_W'(1);
                    if (dec_op == OP_HALT) halted <= 1'b1;
                end
                S_EXEC: begin
                    if (acc_wr_c) acc <= bus.alu_out;
                    if (flag_wr_c) begin
                        carry_flag <= bus.alu_carry;
                        zero_flag  <= bus.alu_zero;
                    end
                end
                S_IO_WAIT: begin
                    if (in_ready_c && bus.in_valid) acc <= bus.in_data;
                end
                default: ;
            endcase
        end
    end

    assign bus.imem_addr  = pc;
    assign bus.dmem_addr  = ir_arg;
    assign bus.dmem_wdata = acc;
    assign bus.dmem_we    = dmem_we_c;
    assign bus.alu_op     = alu_op_c;
    assign bus.alu_a      = acc;
    assign bus.alu_b      = mem_operand_c ? bus.dmem_rdata : ir_arg;
    assign bus.in_ready   = in_ready_c;
    assign bus.out_data   = acc;
    assign bus.out_valid  = out_valid_c;
    assign bus.acc        = acc;
    assign bus.carry_flag = carry_flag;
    assign bus.zero_flag  = zero_flag;
    assign bus.halted     = halted;
endmodule

// File: tb/tb_nibble_seq.sv
// Directed bench for nibble_seq with behavioural ROM, RAM and ALU models;
// every check is sampled on the falling clock edge.
module tb_nibble_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    nibble_seq_if bus();
    nibble_seq #(.RESET_PC(8'h00)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [11:0] rom [256];
    logic [3:0]  ram [16];
    logic        poke_en = 1'b0;
    logic [3:0]  poke_addr = 4'h0;
    logic [3:0]  poke_data = 4'h0;
    logic [4:0]  alu_t;
    int vectors = 0;
    int errors  = 0;

    always @(posedge clk) bus.imem_data <= rom[bus.imem_addr];

    always @(posedge clk) begin
        if (poke_en) ram[poke_addr] <= poke_data;
        else if (bus.dmem_we) ram[bus.dmem_addr] <= bus.dmem_wdata;
        bus.dmem_rdata <= ram[bus.dmem_addr];
    end

    // ALU model: CMP carry is the borrow of a-b, zero reflects the 4-bit result.
    always_comb begin
        alu_t = 5'd0;
        bus.alu_out = bus.alu_a;
        bus.alu_carry = 1'b0;
        case (bus.alu_op)
            3'b001: begin alu_t = {1'b0, bus.alu_a} - {1'b0, bus.alu_b}; bus.alu_out = alu_t[3:0]; bus.alu_carry = alu_t[4]; end
            3'b010: bus.alu_out = bus.alu_b;
            3'b011: begin alu_t = {1'b0, bus.alu_a} + {1'b0, bus.alu_b}; bus.alu_out = alu_t[3:0]; bus.alu_carry = alu_t[4]; end
            3'b100: bus.alu_out = ~(bus.alu_a | bus.alu_b);
            default: bus.alu_out = bus.alu_a;
        endcase
        bus.alu_zero = (bus.alu_out == 4'h0);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic begin_prog();
        @(negedge clk);
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = 4'h0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = 12'hF00;
    endtask

    task automatic ram_poke(input logic [3:0] a, input logic [3:0] d);
        poke_addr = a;
        poke_data = d;
        poke_en = 1'b1;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    task automatic run();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        begin_prog();
        #1;
        vectors++; if (bus.acc !== 4'h0) begin errors++; $display("FAIL rst_acc: got %h exp 0", bus.acc); end
        vectors++; if (bus.carry_flag !== 1'b0) begin errors++; $display("FAIL rst_carry: got %b exp 0", bus.carry_flag); end
        vectors++; if (bus.zero_flag !== 1'b0) begin errors++; $display("FAIL rst_zero: got %b exp 0", bus.zero_flag); end
        vectors++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL rst_halted: got %b exp 0", bus.halted); end
        vectors++; if (bus.dmem_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b exp 0", bus.dmem_we); end
        vectors++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_hs: got rdy %b vld %b exp 0 0", bus.in_ready, bus.out_valid); end
        vectors++; if (bus.imem_addr !== 8'h00) begin errors++; $display("FAIL rst_pc: got %h exp 00", bus.imem_addr); end
    endtask

    task automatic test_add_halt();
        begin_prog();
        rom[0] = 12'h009; rom[1] = 12'h508;
        run();
        step(7);
        vectors++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL halt_early: got %b exp 0", bus.halted); end
        step(1);
        vectors++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL halt_at8: got %b exp 1", bus.halted); end
        vectors++; if (bus.acc !== 4'h1) begin errors++; $display("FAIL add_acc: got %h exp 1", bus.acc); end
        vectors++; if (bus.carry_flag !== 1'b1 || bus.zero_flag !== 1'b0) begin errors++; $display("FAIL add_flags: got c%b z%b exp c1 z0", bus.carry_flag, bus.zero_flag); end
        step(3);
        vectors++; if (bus.imem_addr !== 8'h03 || bus.acc !== 4'h1 || bus.halted !== 1'b1) begin errors++; $display("FAIL halt_frozen: got pc %h acc %h h %b exp 03 1 1", bus.imem_addr, bus.acc, bus.halted); end
    endtask

    task automatic test_cmpm_jz();
        begin_prog();
        rom[0] = 12'h005; rom[1] = 12'h803; rom[2] = 12'hC10;
        ram_poke(4'd3, 4'd5);
        run();
        step(6);
        vectors++; if (bus.zero_flag !== 1'b0) begin errors++; $display("FAIL cmpm_early: got z%b exp 0", bus.zero_flag); end
        step(1);
        vectors++; if (bus.zero_flag !== 1'b1 || bus.carry_flag !== 1'b0) begin errors++; $display("FAIL cmpm_flags: got c%b z%b exp c0 z1", bus.carry_flag, bus.zero_flag); end
        vectors++; if (bus.acc !== 4'h5) begin errors++; $display("FAIL cmpm_acc: got %h exp 5", bus.acc); end
        step(2);
        vectors++; if (bus.imem_addr !== 8'h10) begin errors++; $display("FAIL jz_target: got %h exp 10", bus.imem_addr); end
    endtask

    task automatic test_st_ld();
        begin_prog();
        rom[0] = 12'h007; rom[1] = 12'h302; rom[2] = 12'h000; rom[3] = 12'h202;
        ram_poke(4'd2, 4'd0);
        run();
        step(4);
        vectors++; if (bus.dmem_we !== 1'b0) begin errors++; $display("FAIL st_we_pre: got %b exp 0", bus.dmem_we); end
        step(1);
        vectors++; if (bus.dmem_we !== 1'b1 || bus.dmem_addr !== 4'h2 || bus.dmem_wdata !== 4'h7) begin errors++; $display("FAIL st_strobe: got we%b a%h d%h exp we1 a2 d7", bus.dmem_we, bus.dmem_addr, bus.dmem_wdata); end
        step(1);
        vectors++; if (bus.dmem_we !== 1'b0) begin errors++; $display("FAIL st_we_post: got %b exp 0", bus.dmem_we); end
        vectors++; if (ram[2] !== 4'h7) begin errors++; $display("FAIL st_ram: got %h exp 7", ram[2]); end
        step(3);
        vectors++; if (bus.acc !== 4'h0) begin errors++; $display("FAIL lit0_acc: got %h exp 0", bus.acc); end
        step(4);
        vectors++; if (bus.acc !== 4'h7) begin errors++; $display("FAIL ld_acc: got %h exp 7", bus.acc); end
    endtask

    task automatic test_alu_branch();
        begin_prog();
        rom[0] = 12'h005; rom[1] = 12'h902; rom[2] = 12'h709; rom[3] = 12'hC40; rom[4] = 12'hE20;
        run();
        step(6);
        vectors++; if (bus.acc !== 4'h8 || bus.carry_flag !== 1'b0 || bus.zero_flag !== 1'b0) begin errors++; $display("FAIL nori: got acc %h c%b z%b exp 8 c0 z0", bus.acc, bus.carry_flag, bus.zero_flag); end
        step(3);
        vectors++; if (bus.acc !== 4'h8 || bus.carry_flag !== 1'b1 || bus.zero_flag !== 1'b0) begin errors++; $display("FAIL cmpi: got acc %h c%b z%b exp 8 c1 z0", bus.acc, bus.carry_flag, bus.zero_flag); end
        step(2);
        vectors++; if (bus.imem_addr !== 8'h04) begin errors++; $display("FAIL jz_not_taken: got %h exp 04", bus.imem_addr); end
        step(2);
        vectors++; if (bus.imem_addr !== 8'h20) begin errors++; $display("FAIL jc_taken: got %h exp 20", bus.imem_addr); end
    endtask

    task automatic test_io();
        begin_prog();
        rom[0] = 12'h009; rom[1] = 12'h508; rom[2] = 12'h100; rom[3] = 12'h400;
        run();
        step(8);
        vectors++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL in_no_outvld: got %b exp 0", bus.out_valid); end
        for (int i = 0; i < 5; i++) begin
            vectors++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL in_wait%0d: got rdy %b exp 1", i, bus.in_ready); end
            step(1);
        end
        bus.in_valid = 1'b1;
        bus.in_data = 4'h4;
        vectors++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL in_sixth: got rdy %b exp 1", bus.in_ready); end
        step(1);
        bus.in_valid = 1'b0;
        vectors++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL in_done_rdy: got %b exp 0", bus.in_ready); end
        vectors++; if (bus.acc !== 4'h4 || bus.carry_flag !== 1'b1 || bus.zero_flag !== 1'b0) begin errors++; $display("FAIL in_acc: got acc %h c%b z%b exp 4 c1 z0", bus.acc, bus.carry_flag, bus.zero_flag); end
        step(2);
        vectors++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_data !== 4'h4) begin errors++; $display("FAIL out_start: got vld %b rdy %b d %h exp 1 0 4", bus.out_valid, bus.in_ready, bus.out_data); end
        for (int i = 0; i < 3; i++) begin
            step(1);
            vectors++; if (bus.out_valid !== 1'b1 || bus.out_data !== 4'h4) begin errors++; $display("FAIL out_hold%0d: got vld %b d %h exp 1 4", i, bus.out_valid, bus.out_data); end
        end
        bus.out_ready = 1'b1;
        step(1);
        bus.out_ready = 1'b0;
        vectors++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL out_done: got %b exp 0", bus.out_valid); end
        step(2);
        vectors++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL io_halt: got %b exp 1", bus.halted); end
    endtask

    task automatic test_pc_wrap();
        begin_prog();
        rom[0] = 12'hBFF; rom[255] = 12'h006;
        run();
        step(2);
        vectors++; if (bus.imem_addr !== 8'hFF) begin errors++; $display("FAIL jmp_ff: got %h exp ff", bus.imem_addr); end
        step(3);
        vectors++; if (bus.imem_addr !== 8'h00 || bus.acc !== 4'h6) begin errors++; $display("FAIL pc_wrap: got pc %h acc %h exp 00 6", bus.imem_addr, bus.acc); end
    endtask

    task automatic test_reset_abort();
        begin_prog();
        rom[0] = 12'h009; rom[1] = 12'h305;
        ram_poke(4'd5, 4'd0);
        run();
        step(5);
        vectors++; if (bus.dmem_we !== 1'b1) begin errors++; $display("FAIL abort_st_we: got %b exp 1", bus.dmem_we); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (bus.dmem_we !== 1'b0) begin errors++; $display("FAIL abort_st_drop: got %b exp 0", bus.dmem_we); end
        step(2);
        vectors++; if (ram[5] !== 4'h0) begin errors++; $display("FAIL abort_st_ram: got %h exp 0", ram[5]); end
        run();
        vectors++; if (bus.imem_addr !== 8'h00 || bus.acc !== 4'h0) begin errors++; $display("FAIL abort_st_pc: got pc %h acc %h exp 00 0", bus.imem_addr, bus.acc); end

        begin_prog();
        rom[0] = 12'h003; rom[1] = 12'h400;
        run();
        step(5);
        vectors++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL abort_out_vld: got %b exp 1", bus.out_valid); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL abort_out_drop: got vld %b rdy %b exp 0 0", bus.out_valid, bus.in_ready); end
        run();
        vectors++; if (bus.imem_addr !== 8'h00 || bus.acc !== 4'h0) begin errors++; $display("FAIL abort_out_pc: got pc %h acc %h exp 00 0", bus.imem_addr, bus.acc); end
        step(3);
        vectors++; if (bus.acc !== 4'h3) begin errors++; $display("FAIL abort_restart: got %h exp 3", bus.acc); end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data = 4'h0;
        bus.out_ready = 1'b0;
        test_reset();
        test_add_halt();
        test_cmpm_jz();
        test_st_ld();
        test_alu_branch();
        test_io();
        test_pc_wrap();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
